// File: rtl/regfile_param.sv
// Parametrised RV32I general-purpose register file with zero flags and a
// handshaked debug dump engine that streams every register in ascending order.
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   wraddr,
  input  logic [XLEN-1:0] wrdata,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdout1,
  output logic [XLEN-1:0] rdout2,
  output logic [NREGS-1:0] zflag,
  input  logic            dbg_req,
  input  logic            dbg_ready,
  output logic            dbg_valid,
  output logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            dbg_busy,
  output logic            dbg_done
);

  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_PTR = AW'(NREGS - 1);
  localparam bit            ZERO_EN  = (ZERO_REG != 0);
  localparam bit            BYP_EN   = (BYPASS != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  logic [XLEN-1:0] regs_r [NREGS];
  logic            wr_qual_s;
  logic [NREGS-1:0] zflag_s;

  dump_state_t     state_r, state_nx_s;
  logic [AW-1:0]   ptr_r, ptr_nx_s;
  logic [XLEN-1:0] dbg_data_r, dbg_data_nx_s;
  logic [AW-1:0]   dbg_addr_r, dbg_addr_nx_s;
  logic            dbg_valid_r, dbg_busy_r, dbg_done_r;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < NREGS_W);
  endfunction

  // Shared read rule for both ports and the dump capture: zero/out-of-range first, then bypass.
  function automatic logic [XLEN-1:0] read_fn(input logic [AW-1:0]   addr,
                                              input logic [XLEN-1:0] stored,
                                              input logic            wr_hit,
                                              input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] val;
    if (!in_range(addr) || (ZERO_EN && (addr == {AW{1'b0}}))) begin
      val = {XLEN{1'b0}};
    end else if (BYP_EN && wr_hit) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Qualify the write against range and the hardwired-zero register.
  always_comb begin
    wr_qual_s = we && in_range(wraddr) && !(ZERO_EN && (wraddr == {AW{1'b0}}));
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_qual_s) begin
      regs_r[wraddr] <= wrdata;
    end
  end

  assign rdout1 = read_fn(rs1, regs_r[rs1], wr_qual_s && (wraddr == rs1), wrdata);
  assign rdout2 = read_fn(rs2, regs_r[rs2], wr_qual_s && (wraddr == rs2), wrdata);

  // Zero flags come from stored contents only, never from the bypass path.
  always_comb begin
    zflag_s = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      zflag_s[i] = (regs_r[i] == {XLEN{1'b0}});
    end
    if (ZERO_EN) begin
      zflag_s[0] = 1'b1;
    end else begin
      zflag_s[0] = (regs_r[0] == {XLEN{1'b0}});
    end
  end

  assign zflag = zflag_s;

  // Dump engine next-state, pointer and beat capture.
  always_comb begin
    state_nx_s    = state_r;
    ptr_nx_s      = ptr_r;
    dbg_data_nx_s = dbg_data_r;
    dbg_addr_nx_s = dbg_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (dbg_req) begin
          state_nx_s = ST_LOAD;
          ptr_nx_s   = {AW{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        dbg_data_nx_s = read_fn(ptr_r, regs_r[ptr_r], wr_qual_s && (wraddr == ptr_r), wrdata);
        dbg_addr_nx_s = ptr_r;
        state_nx_s    = ST_SEND;
      end
      ST_SEND: begin
        if (dbg_ready) begin
          if (ptr_r == LAST_PTR) begin
            state_nx_s = ST_DONE;
          end else begin
            ptr_nx_s   = ptr_r + AW'(1'b1);
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Dump state and registered handshake outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {AW{1'b0}};
      dbg_data_r  <= {XLEN{1'b0}};
      dbg_addr_r  <= {AW{1'b0}};
      dbg_valid_r <= 1'b0;
      dbg_busy_r  <= 1'b0;
      dbg_done_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      ptr_r       <= ptr_nx_s;
      dbg_data_r  <= dbg_data_nx_s;
      dbg_addr_r  <= dbg_addr_nx_s;
      dbg_valid_r <= (state_nx_s == ST_SEND);
      dbg_busy_r  <= (state_nx_s != ST_IDLE);
      dbg_done_r  <= (state_nx_s == ST_DONE);
    end
  end

  assign dbg_valid = dbg_valid_r;
  assign dbg_addr  = dbg_addr_r;
  assign dbg_data  = dbg_data_r;
  assign dbg_busy  = dbg_busy_r;
  assign dbg_done  = dbg_done_r;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default, no-bypass and 16x12 instances
// compared against an array-based reference model.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus for the 32x32 bypass and no-bypass instances
  logic        we, dbg_req, dbg_ready;
  logic [4:0]  wraddr, rs1, rs2;
  logic [31:0] wrdata;
  logic [31:0] rdout1, rdout2, zflag, dbg_data;
  logic [4:0]  dbg_addr;
  logic        dbg_valid, dbg_busy, dbg_done;
  logic [31:0] nb_rdout1, nb_rdout2, nb_zflag, nb_dbg_data;
  logic [4:0]  nb_dbg_addr;
  logic        nb_dbg_valid, nb_dbg_busy, nb_dbg_done;

  // 16-bit x 12 instance
  logic        s_we, s_dbg_req, s_dbg_ready;
  logic [3:0]  s_wraddr, s_rs1, s_rs2, s_dbg_addr;
  logic [15:0] s_wrdata, s_rdout1, s_rdout2, s_dbg_data;
  logic [11:0] s_zflag;
  logic        s_dbg_valid, s_dbg_busy, s_dbg_done;

  logic [31:0] model [32];
  logic [15:0] s_model [12];
  int n_checks = 0;
  int n_fail = 0;

  regfile_param u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wraddr(wraddr), .wrdata(wrdata),
    .rs1(rs1), .rs2(rs2), .rdout1(rdout1), .rdout2(rdout2), .zflag(zflag),
    .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_valid(dbg_valid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_busy(dbg_busy), .dbg_done(dbg_done));

  regfile_param #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .wraddr(wraddr), .wrdata(wrdata),
    .rs1(rs1), .rs2(rs2), .rdout1(nb_rdout1), .rdout2(nb_rdout2), .zflag(nb_zflag),
    .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_valid(nb_dbg_valid),
    .dbg_addr(nb_dbg_addr), .dbg_data(nb_dbg_data), .dbg_busy(nb_dbg_busy), .dbg_done(nb_dbg_done));

  regfile_param #(.XLEN(16), .NREGS(12)) u_small (
    .clk(clk), .rst_n(rst_n), .we(s_we), .wraddr(s_wraddr), .wrdata(s_wrdata),
    .rs1(s_rs1), .rs2(s_rs2), .rdout1(s_rdout1), .rdout2(s_rdout2), .zflag(s_zflag),
    .dbg_req(s_dbg_req), .dbg_ready(s_dbg_ready), .dbg_valid(s_dbg_valid),
    .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data), .dbg_busy(s_dbg_busy), .dbg_done(s_dbg_done));

  task automatic test_reset();
    rst_n = 1'b0; rs1 = 5'd5; rs2 = 5'd9;
    @(negedge clk); @(negedge clk); #1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 12; i++) s_model[i] = 16'h0;
    n_checks++; if (rdout1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdout1 got %h exp %h", rdout1, 32'h0); end
    n_checks++; if (rdout2 !== 32'h0) begin n_fail++; $display("FAIL reset_rdout2 got %h exp %h", rdout2, 32'h0); end
    n_checks++; if (zflag !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_zflag got %h exp %h", zflag, 32'hFFFFFFFF); end
    n_checks++; if (dbg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dbg_valid); end
    n_checks++; if (dbg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", dbg_busy); end
    n_checks++; if (nb_dbg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nb_valid got %b exp 0", nb_dbg_valid); end
    n_checks++; if (s_zflag !== 12'hFFF) begin n_fail++; $display("FAIL reset_s_zflag got %h exp %h", s_zflag, 12'hFFF); end
    n_checks++; if (s_dbg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_s_busy got %b exp 0", s_dbg_busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_zero();
    @(negedge clk); we = 1'b1; wraddr = 5'd5; wrdata = 32'h20; rs1 = 5'd5;
    @(negedge clk); we = 1'b0; model[5] = 32'h20; #1;
    n_checks++; if (rdout1 !== 32'h20) begin n_fail++; $display("FAIL wr_x5 got %h exp %h", rdout1, 32'h20); end
    n_checks++; if (nb_rdout1 !== 32'h20) begin n_fail++; $display("FAIL wr_x5_nb got %h exp %h", nb_rdout1, 32'h20); end
    n_checks++; if (zflag[5] !== 1'b0) begin n_fail++; $display("FAIL zflag5 got %b exp 0", zflag[5]); end
    @(negedge clk); we = 1'b1; wraddr = 5'd0; wrdata = 32'hDEAD; rs1 = 5'd0; rs2 = 5'd0; #1;
    n_checks++; if (rdout1 !== 32'h0) begin n_fail++; $display("FAIL x0_same_cycle got %h exp 0", rdout1); end
    @(negedge clk); we = 1'b0; #1;
    n_checks++; if (rdout2 !== 32'h0) begin n_fail++; $display("FAIL x0_read got %h exp 0", rdout2); end
    n_checks++; if (zflag[0] !== 1'b1) begin n_fail++; $display("FAIL zflag0 got %b exp 1", zflag[0]); end
  endtask

  task automatic test_bypass();
    @(negedge clk); we = 1'b1; wraddr = 5'd6; wrdata = 32'h1C; rs2 = 5'd6; #1;
    n_checks++; if (rdout2 !== 32'h1C) begin n_fail++; $display("FAIL bypass_on got %h exp %h", rdout2, 32'h1C); end
    n_checks++; if (nb_rdout2 !== model[6]) begin n_fail++; $display("FAIL bypass_off got %h exp %h", nb_rdout2, model[6]); end
    n_checks++; if (zflag[6] !== 1'b1) begin n_fail++; $display("FAIL zflag_not_bypassed got %b exp 1", zflag[6]); end
    model[6] = 32'h1C;
    @(negedge clk); wraddr = 5'd4; wrdata = 32'd9;
    @(negedge clk); we = 1'b0; model[4] = 32'd9; #1;
    n_checks++; if (nb_rdout2 !== 32'h1C) begin n_fail++; $display("FAIL bypass_off_next got %h exp %h", nb_rdout2, 32'h1C); end
  endtask

  task automatic test_full_dump();
    int cyc; int beat; bit done_seen;
    dbg_ready = 1'b1;
    @(negedge clk); dbg_req = 1'b1;
    @(negedge clk); dbg_req = 1'b0;
    cyc = 1; beat = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 200) begin
      if (dbg_done) begin
        done_seen = 1'b1;
        n_checks++; if (cyc !== 65) begin n_fail++; $display("FAIL dump_done_cycle got %0d exp 65", cyc); end
        n_checks++; if (beat !== 32) begin n_fail++; $display("FAIL dump_beats got %0d exp 32", beat); end
        n_checks++; if (nb_dbg_done !== 1'b1) begin n_fail++; $display("FAIL nb_dump_done got %b exp 1", nb_dbg_done); end
      end else if (dbg_valid) begin
        n_checks++; if (dbg_addr !== 5'(beat)) begin n_fail++; $display("FAIL dump_addr got %0d exp %0d", dbg_addr, beat); end
        n_checks++; if (dbg_data !== model[beat]) begin n_fail++; $display("FAIL dump_data[%0d] got %h exp %h", beat, dbg_data, model[beat]); end
        n_checks++; if (nb_dbg_data !== model[beat] || nb_dbg_addr !== 5'(beat)) begin n_fail++; $display("FAIL nb_dump[%0d] got %h exp %h", beat, nb_dbg_data, model[beat]); end
        beat++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++; if (!done_seen) begin n_fail++; $display("FAIL dump_timeout got no done exp done"); end
    n_checks++; if (dbg_done !== 1'b0 || dbg_busy !== 1'b0) begin n_fail++; $display("FAIL dump_after got done=%b busy=%b exp 0/0", dbg_done, dbg_busy); end
  endtask

  task automatic test_backpressure();
    int beat; int hold; bit done_seen; logic [31:0] old3; logic [31:0] exp_d;
    dbg_ready = 1'b1; old3 = model[3];
    @(negedge clk); dbg_req = 1'b1;
    @(negedge clk); dbg_req = 1'b0;
    beat = 0; hold = 0; done_seen = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      we = 1'b0;
      if (dbg_done) begin
        done_seen = 1'b1;
        n_checks++; if (beat !== 32) begin n_fail++; $display("FAIL bp_beats got %0d exp 32", beat); end
      end else if (dbg_valid) begin
        exp_d = (beat == 3) ? old3 : model[beat];
        n_checks++; if (dbg_addr !== 5'(beat)) begin n_fail++; $display("FAIL bp_addr got %0d exp %0d", dbg_addr, beat); end
        n_checks++; if (dbg_data !== exp_d) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp %h", beat, dbg_data, exp_d); end
        if (beat == 3 && hold < 5) begin
          dbg_ready = 1'b0;
          if (hold == 0) begin we = 1'b1; wraddr = 5'd3; wrdata = 32'h77; end
          else if (hold == 1) begin we = 1'b1; wraddr = 5'd10; wrdata = 32'h55; end
          hold++;
        end else begin
          dbg_ready = 1'b1;
          if (beat == 10) begin
            n_checks++; if (dbg_data !== 32'h55) begin n_fail++; $display("FAIL bp_beat10 got %h exp %h", dbg_data, 32'h55); end
          end
          beat++;
        end
        if (we) model[wraddr] = wrdata;
      end
      @(negedge clk);
    end
    we = 1'b0; dbg_ready = 1'b1;
    n_checks++; if (!done_seen || hold !== 5) begin n_fail++; $display("FAIL bp_timeout got done=%b hold=%0d exp 1/5", done_seen, hold); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, n1, n2, ez;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      we     = 1'($urandom_range(0, 1));
      wraddr = 5'($urandom_range(0, 31));
      wrdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      rs1    = ($urandom_range(0, 2) == 0) ? wraddr : 5'($urandom_range(0, 31));
      rs2    = ($urandom_range(0, 2) == 0) ? wraddr : 5'($urandom_range(0, 31));
      #1;
      n1 = (rs1 == 5'd0) ? 32'h0 : model[rs1];
      n2 = (rs2 == 5'd0) ? 32'h0 : model[rs2];
      e1 = (we && rs1 != 5'd0 && rs1 == wraddr) ? wrdata : n1;
      e2 = (we && rs2 != 5'd0 && rs2 == wraddr) ? wrdata : n2;
      for (int i = 0; i < 32; i++) ez[i] = (model[i] == 32'h0);
      n_checks++; if (rdout1 !== e1) begin n_fail++; $display("FAIL rnd_rd1 it%0d got %h exp %h", it, rdout1, e1); end
      n_checks++; if (rdout2 !== e2) begin n_fail++; $display("FAIL rnd_rd2 it%0d got %h exp %h", it, rdout2, e2); end
      n_checks++; if (nb_rdout1 !== n1) begin n_fail++; $display("FAIL rnd_nb_rd1 it%0d got %h exp %h", it, nb_rdout1, n1); end
      n_checks++; if (nb_rdout2 !== n2) begin n_fail++; $display("FAIL rnd_nb_rd2 it%0d got %h exp %h", it, nb_rdout2, n2); end
      n_checks++; if (zflag !== ez || nb_zflag !== ez) begin n_fail++; $display("FAIL rnd_zflag it%0d got %h exp %h", it, zflag, ez); end
      if (we && wraddr != 5'd0) model[wraddr] = wrdata;
    end
    @(negedge clk); we = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    bit found; found = 1'b0; dbg_ready = 1'b1;
    @(negedge clk); dbg_req = 1'b1;
    @(negedge clk); dbg_req = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (dbg_valid && dbg_addr == 5'd7) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_find_beat7 got none exp beat 7"); end
    rst_n = 1'b0; dbg_req = 1'b1;
    @(negedge clk); rst_n = 1'b1; dbg_req = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 12; i++) s_model[i] = 16'h0;
    n_checks++; if (dbg_valid !== 1'b0 || dbg_busy !== 1'b0) begin n_fail++; $display("FAIL mid_abort got v=%b b=%b exp 0/0", dbg_valid, dbg_busy); end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (dbg_done !== 1'b0 || dbg_busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_done got d=%b b=%b exp 0/0", dbg_done, dbg_busy); end
      @(negedge clk);
    end
    dbg_req = 1'b1;
    @(negedge clk); dbg_req = 1'b0;
    n_checks++; if (dbg_busy !== 1'b1 || dbg_valid !== 1'b0) begin n_fail++; $display("FAIL restart_load got b=%b v=%b exp 1/0", dbg_busy, dbg_valid); end
    @(negedge clk);
    n_checks++; if (dbg_valid !== 1'b1 || dbg_addr !== 5'd0) begin n_fail++; $display("FAIL restart_addr got v=%b a=%0d exp 1/0", dbg_valid, dbg_addr); end
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_param_sweep();
    int cyc; int beat; bit done_seen;
    @(negedge clk); s_we = 1'b1; s_wraddr = 4'd13; s_wrdata = 16'hBEEF; s_rs1 = 4'd13; #1;
    n_checks++; if (s_rdout1 !== 16'h0) begin n_fail++; $display("FAIL s_oob_bypass got %h exp 0", s_rdout1); end
    @(negedge clk); s_we = 1'b0; #1;
    n_checks++; if (s_rdout1 !== 16'h0) begin n_fail++; $display("FAIL s_oob_read got %h exp 0", s_rdout1); end
    n_checks++; if (s_zflag !== 12'hFFF) begin n_fail++; $display("FAIL s_oob_zflag got %h exp %h", s_zflag, 12'hFFF); end
    @(negedge clk); s_we = 1'b1; s_wraddr = 4'd11; s_wrdata = 16'h1234; s_rs2 = 4'd11; #1;
    n_checks++; if (s_rdout2 !== 16'h1234) begin n_fail++; $display("FAIL s_bypass got %h exp %h", s_rdout2, 16'h1234); end
    @(negedge clk); s_we = 1'b0; s_model[11] = 16'h1234; #1;
    n_checks++; if (s_zflag !== 12'h7FF) begin n_fail++; $display("FAIL s_zflag11 got %h exp %h", s_zflag, 12'h7FF); end
    s_dbg_ready = 1'b1;
    @(negedge clk); s_dbg_req = 1'b1;
    @(negedge clk); s_dbg_req = 1'b0;
    cyc = 1; beat = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 100) begin
      if (s_dbg_done) begin
        done_seen = 1'b1;
        n_checks++; if (beat !== 12 || cyc !== 25) begin n_fail++; $display("FAIL s_dump_end got beats=%0d cyc=%0d exp 12/25", beat, cyc); end
      end else if (s_dbg_valid) begin
        n_checks++; if (s_dbg_addr !== 4'(beat) || s_dbg_data !== s_model[beat]) begin n_fail++; $display("FAIL s_dump[%0d] got a=%0d d=%h exp d=%h", beat, s_dbg_addr, s_dbg_data, s_model[beat]); end
        beat++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++; if (!done_seen) begin n_fail++; $display("FAIL s_dump_timeout got no done exp done"); end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wraddr = 5'd0; wrdata = 32'h0; rs1 = 5'd0; rs2 = 5'd0;
    dbg_req = 1'b0; dbg_ready = 1'b1;
    s_we = 1'b0; s_wraddr = 4'd0; s_wrdata = 16'h0; s_rs1 = 4'd0; s_rs2 = 4'd0;
    s_dbg_req = 1'b0; s_dbg_ready = 1'b1;
    test_reset();
    test_write_zero();
    test_bypass();
    test_full_dump();
    test_backpressure();
    test_random();
    test_reset_mid_dump();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
